// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags,
// overflow/underflow error pulses and an optional first-word-fall-through read port.
module sync_fifo_ext #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned AFULL_THRESH  = 6,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter int unsigned FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  rd_ok;
    logic                  wr_ok;

    // A write into a full FIFO is accepted only when a read frees the head slot in the same edge.
    always_comb begin
        rd_ok = rd & ~empty;
        wr_ok = wr & (~full | rd_ok);
    end

    always_comb begin
        count        = cnt;
        full         = (cnt == DEPTH_C);
        empty        = (cnt == '0);
        almost_full  = (cnt >= AFULL_C);
        almost_empty = (cnt <= AEMPTY_C);
    end

    // Storage is deliberately not reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr & full & ~rd;
            underflow <= rd & empty;
            if (wr_ok) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = mem[r_ptr];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data <= '0;
                end else if (rd_ok) begin
                    r_data <= mem[r_ptr];
                end
            end
        end
    endgenerate

endmodule
